bin2unary_gen: RTL and testbench

Binary-to-unary bitstream generator: accepts a BITWIDTH-bit binary operand over a valid/ready handshake and emits one frame of serial bits whose ones-count equals the operand. It is the encoding-side counterpart of the enable-counter decoder, which accumulates a unary stream back to binary. It feeds the unary subtractor datapath, with stall support via iEn.

---
 rtl/ussub_pkg.sv | 29 ++
 rtl/bin2unary_gen_if.sv | 25 ++
 rtl/bsg_rng.sv | 49 ++++
 rtl/bin2unary_gen.sv | 118 +++++++++++
 tb/tb_bin2unary_gen.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ussub_pkg.sv
// Shared types and elaboration helpers for the unary-stream datapath blocks.
// Holds the stream FSM states, the LFSR tap table and the frame-length helper.
package ussub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Fibonacci taps for a left-shifting LFSR whose feedback enters bit 0;
    // each mask gives a maximal-length sequence of 2^bw-1 nonzero states.
    function automatic logic [7:0] lfsrTaps(input int bw);
        case (bw)
            3:       return 8'h06;
            4:       return 8'h0C;
            5:       return 8'h14;
            6:       return 8'h30;
            7:       return 8'h60;
            8:       return 8'hB8;
            default: return 8'h0C;
        endcase
    endfunction

    // The LFSR never visits zero, so its frame is one position shorter.
    function automatic int frameLen(input int bw, input int mode);
        return (mode == 0) ? (1 << bw) : ((1 << bw) - 1);
    endfunction

endpackage

// File: rtl/bin2unary_gen_if.sv
// Operand handshake and serial stream bundle for bin2unary_gen.
// master drives the operand, stall and abort; slave returns the stream.
interface bin2unary_gen_if #(
    parameter int BITWIDTH = 4
);
    logic                iClr;
    logic [BITWIDTH-1:0] iVal;
    logic                iValVld;
    logic                oValRdy;
    logic                iEn;
    logic                oBit;
    logic                oBitVld;
    logic                oLast;
    logic                oBusy;

    modport master (
        output iClr, iVal, iValVld, iEn,
        input  oValRdy, oBit, oBitVld, oLast, oBusy
    );

    modport slave (
        input  iClr, iVal, iValVld, iEn,
        output oValRdy, oBit, oBitVld, oLast, oBusy
    );
endinterface

// File: rtl/bsg_rng.sv
// Index source for the unary stream: an up-counter (thermometer code) or a
// maximal-length Fibonacci LFSR (stochastic code), reloaded at frame start.
module bsg_rng
    import ussub_pkg::*;
#(
    parameter int BITWIDTH  = 4,
    parameter int RNG_MODE  = 0,
    parameter int LFSR_SEED = 1
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iClr,
    input  logic                iLoad,
    input  logic                iEn,
    output logic [BITWIDTH-1:0] oIdx
);

    localparam logic [BITWIDTH-1:0] LOAD_VAL =
        (RNG_MODE == 0) ? '0 : BITWIDTH'(LFSR_SEED);

    logic [BITWIDTH-1:0] rIdx;
    logic [BITWIDTH-1:0] stepIdx;

    generate
        if (RNG_MODE == 0) begin : gCounter
            assign stepIdx = rIdx + BITWIDTH'(1);
        end else begin : gLfsr
            localparam logic [7:0] TAPS = lfsrTaps(BITWIDTH);
            logic [BITWIDTH-1:0] tapBits;
            for (genvar gi = 0; gi < BITWIDTH; gi++) begin : gTap
                assign tapBits[gi] = rIdx[gi] & TAPS[gi];
            end
            assign stepIdx = {rIdx[BITWIDTH-2:0], ^tapBits};
        end
    endgenerate

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            rIdx <= LOAD_VAL;
        end else if (iClr || iLoad) begin
            rIdx <= LOAD_VAL;
        end else if (iEn) begin
            rIdx <= stepIdx;
        end
    end

    assign oIdx = rIdx;

endmodule

// File: rtl/bin2unary_gen.sv
// Binary-to-unary bitstream generator: latches an operand and emits one frame
// of serial bits whose ones-count equals it, stallable through iEn.
module bin2unary_gen
    import ussub_pkg::*;
#(
    parameter int BITWIDTH  = 4,
    parameter int RNG_MODE  = 0,
    parameter int LFSR_SEED = 1
) (
    input logic            iClk,
    input logic            iRstN,
    bin2unary_gen_if.slave bus
);

    localparam int              FRAME    = frameLen(BITWIDTH, RNG_MODE);
    localparam logic [BITWIDTH:0] LAST_POS = (BITWIDTH + 1)'(FRAME - 1);

    state_t              rState;
    state_t              stateNext;
    logic [BITWIDTH-1:0] rVal;
    logic [BITWIDTH:0]   rPos;
    logic [BITWIDTH-1:0] idx;
    logic                valRdy;
    logic                load;
    logic                step;
    logic                bitNext;
    logic                rBit;
    logic                rBitVld;
    logic                rLast;
    logic                rBusy;

    assign valRdy = (rState == IDLE) & ~bus.iClr;
    assign load   = bus.iValVld & valRdy;
    assign step   = (rState == RUN) & bus.iEn & ~bus.iClr;

    // Counter mode sweeps 0..FRAME-1, LFSR mode sweeps 1..2^BITWIDTH-1, so
    // the comparison differs by one to keep the ones-count equal to rVal.
    generate
        if (RNG_MODE == 0) begin : gCmpLt
            assign bitNext = (idx < rVal);
        end else begin : gCmpLe
            assign bitNext = (idx <= rVal);
        end
    endgenerate

    bsg_rng #(
        .BITWIDTH (BITWIDTH),
        .RNG_MODE (RNG_MODE),
        .LFSR_SEED(LFSR_SEED)
    ) uRng (
        .iClk (iClk),
        .iRstN(iRstN),
        .iClr (bus.iClr),
        .iLoad(load),
        .iEn  (step),
        .oIdx (idx)
    );

    always_comb begin
        stateNext = rState;
        if (bus.iClr) begin
            stateNext = IDLE;
        end else begin
            case (rState)
                IDLE:    if (load) stateNext = RUN;
                RUN:     if (bus.iEn && (rPos == LAST_POS)) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            rState <= IDLE;
        end else begin
            rState <= stateNext;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            rVal    <= '0;
            rPos    <= '0;
            rBit    <= 1'b0;
            rBitVld <= 1'b0;
            rLast   <= 1'b0;
            rBusy   <= 1'b0;
        end else if (bus.iClr) begin
            rPos    <= '0;
            rBit    <= 1'b0;
            rBitVld <= 1'b0;
            rLast   <= 1'b0;
            rBusy   <= 1'b0;
        end else begin
            rBusy <= (stateNext == RUN);
            if (load) begin
                rVal <= bus.iVal;
                rPos <= '0;
            end
            if (step) begin
                rBit    <= bitNext;
                rBitVld <= 1'b1;
                rLast   <= (rPos == LAST_POS);
                rPos    <= rPos + (BITWIDTH + 1)'(1);
            end else begin
                rBitVld <= 1'b0;
                rLast   <= 1'b0;
            end
        end
    end

    assign bus.oValRdy = valRdy;
    assign bus.oBit    = rBit;
    assign bus.oBitVld = rBitVld;
    assign bus.oLast   = rLast;
    assign bus.oBusy   = rBusy;

endmodule

// File: tb/tb_bin2unary_gen.sv
// Directed bench for bin2unary_gen: a thermometer instance and an LFSR
// instance driven from a vector table plus clear and reset sequences.
module tb_bin2unary_gen;

    logic iClk;
    logic iRstN;
    int   nCmp;
    int   nErr;

    bin2unary_gen_if #(.BITWIDTH(4)) bus0 ();
    bin2unary_gen_if #(.BITWIDTH(4)) bus1 ();

    bin2unary_gen #(.BITWIDTH(4), .RNG_MODE(0), .LFSR_SEED(1)) dut0 (
        .iClk (iClk),
        .iRstN(iRstN),
        .bus  (bus0)
    );

    bin2unary_gen #(.BITWIDTH(4), .RNG_MODE(1), .LFSR_SEED(1)) dut1 (
        .iClk (iClk),
        .iRstN(iRstN),
        .bus  (bus1)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        int         d;
        logic [3:0] val;
        bit         alt;
        bit         b2b;
        logic [15:0] expBits;
        int         expLen;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setIn(input int d, input logic vld, input logic [3:0] val,
                         input logic en, input logic clr);
        if (d == 0) begin
            bus0.iValVld = vld; bus0.iVal = val; bus0.iEn = en; bus0.iClr = clr;
            bus1.iValVld = 1'b0; bus1.iEn = 1'b0; bus1.iClr = 1'b0;
        end else begin
            bus1.iValVld = vld; bus1.iVal = val; bus1.iEn = en; bus1.iClr = clr;
            bus0.iValVld = 1'b0; bus0.iEn = 1'b0; bus0.iClr = 1'b0;
        end
    endtask

    task automatic getOut(input int d, output logic b, output logic v, output logic l,
                          output logic r, output logic u);
        if (d == 0) begin
            b = bus0.oBit; v = bus0.oBitVld; l = bus0.oLast; r = bus0.oValRdy; u = bus0.oBusy;
        end else begin
            b = bus1.oBit; v = bus1.oBitVld; l = bus1.oLast; r = bus1.oValRdy; u = bus1.oBusy;
        end
    endtask

    // Handshake edge, then the cycle after it must be a bubble with busy set.
    task automatic doLoad(input int d, input logic [3:0] val);
        logic b, v, l, r, u;
        setIn(d, 1'b1, val, 1'b0, 1'b0);
        @(posedge iClk); #1;
        setIn(d, 1'b0, 4'd0, 1'b0, 1'b0);
        getOut(d, b, v, l, r, u);
        chk("load_bubble_vld", {31'd0, v}, 32'd0);
        chk("load_busy", {31'd0, u}, 32'd1);
    endtask

    task automatic runFrame(input int d, input bit alt, output logic [15:0] bits,
                            output int nBits, output int cycles, output bit vldOk,
                            output bit rdyAtLast, output bit gotLast);
        logic b, v, l, r, u;
        logic en;
        bits = '0; nBits = 0; cycles = 0; vldOk = 1'b1; rdyAtLast = 1'b0; gotLast = 1'b0;
        for (int c = 0; c < 100 && !gotLast; c++) begin
            en = alt ? ((c % 2) == 0) : 1'b1;
            setIn(d, 1'b0, 4'd0, en, 1'b0);
            @(posedge iClk); #1;
            getOut(d, b, v, l, r, u);
            cycles = c + 1;
            if (v !== en) vldOk = 1'b0;
            if (v === 1'b1 && nBits < 16) begin
                bits[nBits] = b;
                nBits++;
            end
            if (l === 1'b1) begin
                gotLast   = 1'b1;
                rdyAtLast = r;
            end
        end
        setIn(d, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] bits;
        int          nBits;
        int          cycles;
        bit          vldOk;
        bit          rdyAtLast;
        bit          gotLast;
        logic        b, v, l, r, u;
        bit          runOk;

        nCmp = 0;
        nErr = 0;

        //                d  val    alt   b2b   expBits   len
        tbl[0] = '{0, 4'd5,  1'b0, 1'b0, 16'h001F, 16};
        tbl[1] = '{0, 4'd0,  1'b0, 1'b0, 16'h0000, 16};
        tbl[2] = '{0, 4'd15, 1'b0, 1'b1, 16'h7FFF, 16};
        tbl[3] = '{1, 4'd7,  1'b0, 1'b0, 16'h0537, 15};
        tbl[4] = '{1, 4'd15, 1'b0, 1'b1, 16'h7FFF, 15};
        tbl[5] = '{0, 4'd5,  1'b1, 1'b0, 16'h001F, 16};

        iRstN = 1'b0;
        bus0.iClr = 1'b0; bus0.iVal = '0; bus0.iValVld = 1'b0; bus0.iEn = 1'b0;
        bus1.iClr = 1'b0; bus1.iVal = '0; bus1.iValVld = 1'b0; bus1.iEn = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        for (int d = 0; d < 2; d++) begin
            getOut(d, b, v, l, r, u);
            chk("rst_outs", {28'd0, b, v, l, u}, 32'd0);
            chk("rst_rdy", {31'd0, r}, 32'd1);
        end
        iRstN = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (!tbl[i].b2b) begin
                repeat (2) @(posedge iClk);
                #1;
            end
            doLoad(tbl[i].d, tbl[i].val);
            runFrame(tbl[i].d, tbl[i].alt, bits, nBits, cycles, vldOk, rdyAtLast, gotLast);
            $display("vec %0d dut%0d val=%0d bits=%04h len=%0d cycles=%0d",
                     i, tbl[i].d, tbl[i].val, bits, nBits, cycles);
            chk("frame_last_seen", {31'd0, gotLast}, 32'd1);
            chk("frame_bits", {16'd0, bits}, {16'd0, tbl[i].expBits});
            chk("frame_len", nBits, tbl[i].expLen);
            chk("frame_ones", $countones(bits), {28'd0, tbl[i].val});
            chk("frame_cycles", cycles, tbl[i].alt ? 2 * tbl[i].expLen - 1 : tbl[i].expLen);
            chk("frame_vld_pattern", {31'd0, vldOk}, 32'd1);
            chk("rdy_at_last", {31'd0, rdyAtLast}, 32'd1);
        end

        // Abort mid-frame with a competing operand on the handshake.
        repeat (2) @(posedge iClk);
        #1;
        doLoad(0, 4'd9);
        runOk = 1'b1;
        for (int k = 0; k < 8; k++) begin
            setIn(0, 1'b1, 4'd2, 1'b1, 1'b0);
            #1;
            if (bus0.oValRdy !== 1'b0) runOk = 1'b0;
            @(posedge iClk); #1;
            if (bus0.oBitVld !== 1'b1 || bus0.oBit !== 1'b1) runOk = 1'b0;
        end
        $display("clr: 8 bits of operand 9 streamed with iValVld held");
        chk("run_ignores_vld", {31'd0, runOk}, 32'd1);
        setIn(0, 1'b1, 4'd3, 1'b1, 1'b1);
        #1;
        chk("clr_rdy_low", {31'd0, bus0.oValRdy}, 32'd0);
        @(posedge iClk); #1;
        chk("clr_outs", {28'd0, bus0.oBit, bus0.oBitVld, bus0.oLast, bus0.oBusy}, 32'd0);
        setIn(0, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        chk("clr_rdy_after", {31'd0, bus0.oValRdy}, 32'd1);
        @(posedge iClk); #1;
        chk("clr_no_load", {31'd0, bus0.oBusy}, 32'd0);
        $display("clr: abort applied, no load taken");

        // Asynchronous reset in the middle of a frame.
        doLoad(0, 4'd5);
        for (int k = 0; k < 4; k++) begin
            setIn(0, 1'b0, 4'd0, 1'b1, 1'b0);
            @(posedge iClk); #1;
        end
        chk("pre_rst_vld", {31'd0, bus0.oBitVld}, 32'd1);
        #2;
        iRstN = 1'b0;
        #1;
        chk("async_rst_outs", {28'd0, bus0.oBit, bus0.oBitVld, bus0.oLast, bus0.oBusy}, 32'd0);
        @(posedge iClk); #1;
        iRstN = 1'b1;
        setIn(0, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        chk("post_rst_rdy", {31'd0, bus0.oValRdy}, 32'd1);
        @(posedge iClk); #1;
        doLoad(0, 4'd5);
        runFrame(0, 1'b0, bits, nBits, cycles, vldOk, rdyAtLast, gotLast);
        $display("rst: reload val=5 bits=%04h len=%0d cycles=%0d", bits, nBits, cycles);
        chk("post_rst_last", {31'd0, gotLast}, 32'd1);
        chk("post_rst_bits", {16'd0, bits}, 32'h001F);
        chk("post_rst_len", nBits, 16);

        $display("== %0d vectors applied, %0d miscompares ==", nCmp, nErr);
        $finish;
    end

endmodule
